// File: rtl/ossc_ctrl_pkg.sv
// Shared control-block definitions for the front-panel button logic.
//   btn_state_t           : per-button debounce FSM state
//   BTN_*_DEF             : default button count and timing at 27 MHz
package ossc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  localparam int BTN_NUM_DEF          = 2;
  localparam int BTN_DEBOUNCE_CYC_DEF = 270000;    // 10 ms at 27 MHz
  localparam int BTN_LONG_CYC_DEF     = 27000000;  // 1 s at 27 MHz

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional long-press
// detector and registered outputs.
// Optional feature macro: BTN_LONGPRESS_EN (long-press pulse on long_o).
// Ports:
//   clk27, clk_reset_n : clock, async active-low reset
//   btn_n_i            : raw asynchronous button, active-low
//   state_o            : debounced pressed level, active-high
//   press_o/release_o  : one-cycle pulse per accepted press / release
//   long_o             : one-cycle pulse once per hold of LONG_CYC cycles
module btn_debounce_ch
  import ossc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = BTN_LONG_CYC_DEF
) (
  input  logic clk27,
  input  logic clk_reset_n,
  input  logic btn_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int            CW       = $clog2(LONG_CYC);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [1:0]    sync_q;
  logic          btn_low;
  btn_state_t    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_evt, rel_evt, long_evt;
  logic [2:0]    ev_q;

  // Synchronizer flops reset to 0, which reads as "pressed"; the first
  // released samples after reset abort that phantom press long before the
  // debounce count (>= 2) can complete.
  always_ff @(posedge clk27 or negedge clk_reset_n)
    if (!clk_reset_n) sync_q <= '0;
    else              sync_q <= {sync_q[0], btn_n_i};

  assign btn_low = ~sync_q[1];

  always_ff @(posedge clk27 or negedge clk_reset_n)
    if (!clk_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end

  // The counter is held at 0 in the stable states so every debounce window
  // starts from 0; it saturates instead of wrapping.
  always_comb begin
    nxt       = state;
    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_low) nxt = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!btn_low) nxt = IDLE;
        else if (cnt == DEB_LAST) begin
          nxt       = PRESSED;
          press_evt = 1'b1;
        end
      end
      PRESSED: begin
        cnt_nxt = '0;
        if (!btn_low) nxt = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (btn_low) nxt = PRESSED;
        else if (cnt == DEB_LAST) begin
          nxt     = IDLE;
          rel_evt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef BTN_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

  // Hold counter advances only in PRESSED, so release bounces pause it
  // rather than restart it; long_done blocks a repeat (also covers the case
  // where the counter saturates exactly at LONG_LAST).
  logic [CW-1:0] hold_cnt;
  logic          long_done;

  always_comb long_evt = (state == PRESSED) && (hold_cnt == LONG_LAST) && !long_done;

  always_ff @(posedge clk27 or negedge clk_reset_n)
    if (!clk_reset_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else if (press_evt) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      if (state == PRESSED && hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + CW'(1);
      if (long_evt) long_done <= 1'b1;
    end
`else
  assign long_evt = 1'b0;
`endif

  // Event flags pass through one extra register so each pulse lands on the
  // same edge that state_o (derived from the registered state) changes.
  always_ff @(posedge clk27 or negedge clk_reset_n)
    if (!clk_reset_n) begin
      ev_q      <= '0;
      state_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      ev_q                         <= {long_evt, rel_evt, press_evt};
      state_o                      <= (state == PRESSED) || (state == DEB_RELEASE);
      {long_o, release_o, press_o} <= ev_q;
    end

endmodule

// File: rtl/btn_conditioner.sv
// Front-panel button conditioner: NUM_BTN independent debounce channels plus
// a wrapping count of accepted presses across all buttons.
// Optional feature macro: BTN_LONGPRESS_EN (enables btn_long_o pulses).
// Ports:
//   clk27, clk_reset_n : 27 MHz clock, async active-low reset
//   btn_n_i            : raw buttons, active-low
//   btn_state_o        : debounced pressed state, active-high
//   btn_press_o        : one-cycle pulse per accepted press
//   btn_release_o      : one-cycle pulse per accepted release
//   btn_long_o         : one-cycle long-press pulse (0 without the macro)
//   evt_cnt_o          : 8-bit wrapping count of accepted presses
module btn_conditioner
  import ossc_ctrl_pkg::*;
#(
  parameter int NUM_BTN      = BTN_NUM_DEF,
  parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = BTN_LONG_CYC_DEF
) (
  input  logic               clk27,
  input  logic               clk_reset_n,
  input  logic [NUM_BTN-1:0] btn_n_i,
  output logic [NUM_BTN-1:0] btn_state_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_BTN-1:0] btn_long_o,
  output logic [7:0]         evt_cnt_o
);

  logic [7:0] press_sum;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .clk27       (clk27),
      .clk_reset_n (clk_reset_n),
      .btn_n_i     (btn_n_i[g]),
      .state_o     (btn_state_o[g]),
      .press_o     (btn_press_o[g]),
      .release_o   (btn_release_o[g]),
      .long_o      (btn_long_o[g])
    );
  end

  // Simultaneous presses each count, so add the population count.
  always_comb begin
    press_sum = '0;
    for (int i = 0; i < NUM_BTN; i++) press_sum = press_sum + 8'(btn_press_o[i]);
  end

  always_ff @(posedge clk27 or negedge clk_reset_n)
    if (!clk_reset_n) evt_cnt_o <= '0;
    else              evt_cnt_o <= evt_cnt_o + press_sum;

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 2, number of front-panel buttons.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 270000, clk27 cycles of stable level (10 ms) needed to accept a transition; legal range 2 or more.
REQ-003 SHALL have parameter LONG_CYC, default 27000000, clk27 cycles of held press (1 s) before a long-press event; must exceed DEBOUNCE_CYC.
REQ-004 SHALL have port clk27, input, 1, 27 MHz free-running clock.
REQ-005 SHALL have port clk_reset_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port btn_n_i, input, NUM_BTN, raw asynchronous buttons, active-low.
REQ-007 SHALL have port btn_state_o, output, NUM_BTN, debounced pressed state, active-high.
REQ-008 SHALL have port btn_press_o, output, NUM_BTN, one-cycle pulse per accepted press.
REQ-009 SHALL have port btn_release_o, output, NUM_BTN, one-cycle pulse per accepted release.
REQ-010 SHALL have port btn_long_o, output, NUM_BTN, one-cycle long-press pulse (REQ-025).
REQ-011 SHALL have port evt_cnt_o, output, 8, wrapping count of accepted presses over all buttons.

Function
REQ-012 SHALL pass each btn_n_i bit through a 2-flop synchronizer on clk27 before any use.
REQ-013 SHALL run one independent FSM per button with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-014 SHALL move IDLE->DEB_PRESS when the synced input is low, clearing that button's counter.
REQ-015 SHALL return DEB_PRESS->IDLE with no pulse if the synced input goes high before the count completes (glitch reject).
REQ-016 SHALL move DEB_PRESS->PRESSED when the counter reaches DEBOUNCE_CYC-1, and pulse btn_press_o on that same cycle.
REQ-017 SHALL move PRESSED->DEB_RELEASE when the synced input goes high, clearing the counter.
REQ-018 SHALL return DEB_RELEASE->PRESSED with no new press pulse if the synced input goes low before the count completes.
REQ-019 SHALL move DEB_RELEASE->IDLE when the counter reaches DEBOUNCE_CYC-1, and pulse btn_release_o on that same cycle.
REQ-020 SHALL assert btn_state_o for states PRESSED and DEB_RELEASE, registered.
REQ-021 SHALL register all pulse outputs; btn_press_o SHALL rise exactly DEBOUNCE_CYC+3 clk27 edges after the first edge that samples btn_n_i low, provided the input stays low.
REQ-022 SHALL add the number of btn_press_o bits high in a cycle to evt_cnt_o, so simultaneous presses add 2; the count wraps 255->0.
REQ-023 SHALL size counters with $clog2(LONG_CYC) bits and saturate them, never wrapping.

Reset
REQ-024 SHALL, on clk_reset_n low at any time including mid-debounce, force all FSMs to IDLE and all counters, synchronizers and outputs to 0; no pulse SHALL follow reset release while the buttons are released.

Configuration
REQ-025 SHALL, when BTN_LONGPRESS_EN is defined, pulse btn_long_o once per hold when the PRESSED-state hold counter reaches LONG_CYC-1, with no repeat until the next accepted press.
REQ-026 SHALL, when BTN_LONGPRESS_EN is undefined, tie btn_long_o to 0 and omit the long-press counter logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL place the FSM state enum btn_state_t and the default timing constants in shared package ossc_ctrl_pkg.
REQ-028 SHALL implement the per-button FSM, counter and synchronizer in sub-module btn_debounce_ch, instantiated NUM_BTN times by a generate loop; btn_conditioner adds evt_cnt_o.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20)
REQ-029 SHALL cover: btn_n_i[0] low and held -> btn_press_o[0] pulses 7 cycles later, btn_state_o[0]=1, evt_cnt_o=1.
REQ-030 SHALL cover: btn_n_i[1] low for 3 cycles then high -> no pulse on any output, evt_cnt_o unchanged.
REQ-031 SHALL cover: a pressed button released for 2 cycles then pressed again -> no release pulse and no second press pulse.
REQ-032 SHALL cover: both buttons pressed on the same edge -> both press bits pulse in the same cycle and evt_cnt_o goes from 255 to 1.
REQ-033 SHALL cover: with BTN_LONGPRESS_EN, a 40-cycle hold -> exactly one btn_long_o pulse; without the macro, btn_long_o stays 0.
REQ-034 SHALL cover: reset asserted during DEB_PRESS -> outputs 0 immediately, and no press pulse follows reset release with the button released.
